reg_hex_scan_display: RTL
=========================

Name: reg_hex_scan_display

Overview:
- Board-side consumer of the pipeline core's v0/v1 register taps; sits between the CPU top and the board pins inside the board wrapper.
- Snapshots one selected 32-bit register value per refresh frame, so the display never tears mid-frame.
- Drives an 8-digit, active-low, multiplexed seven-segment display in hex, with optional leading-zero blanking.
- Raises a sticky change flag whenever the displayed value differs between frames.

Parameters:
- REFRESH_DIV, 100000: Clk cycles per digit slot; legal range 2..2^20.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = show all 8 digits.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- v0_In  in  32  register $2 value from core.
- v1_In  in  32  register $3 value from core.
- Sel  in  1  source select: 0 = v0_In, 1 = v1_In; sampled only at frame boundary.
- Ack  in  1  clears Changed.
- An  out  8  digit anodes, active-low, one-hot-low; An[0] = least significant nibble.
- Seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.
- Dp  out  1  decimal point, active-low.
- Changed  out  1  sticky flag: displayed value changed.

Behaviour:
- Reset (Reset = 0, asynchronous), all values held until release:
  - divider count = 0, digit index = 0, snapshot = 0, source flag = 0;
  - An = 8'hFF, Seg = 7'h7F, Dp = 1, Changed = 0.
- Divider:
  - count runs 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted for the single cycle where count == REFRESH_DIV-1.
- Digit index:
  - 3-bit; increments on tick; wraps 7 -> 0.
  - A frame boundary is a tick where index == 7.
- Snapshot, at a frame boundary only:
  - snapshot <= Sel ? v1_In : v0_In;
  - source flag <= Sel.
  - Input changes at any other time have no effect until the next boundary.
- Change detect, at a frame boundary:
  - If the new snapshot differs from the old snapshot AND the new source equals the old source, Changed <= 1.
  - A source switch alone never sets Changed.
  - Ack = 1 clears Changed on the next edge.
  - If set and Ack occur in the same cycle, set wins.
  - The first boundary after reset compares against snapshot 0 / source 0.
- Output stage: An, Seg and Dp are registered, computed from the current index and snapshot, and lag index/snapshot updates by exactly 1 cycle.
- Per-digit outputs for digit i = index:
  - nibble = snapshot[4i+3:4i];
  - An = ~(8'b1 << i);
  - Seg = hex(nibble);
  - Dp = 0 only when i == 0 and source flag == 1, else 1.
- Blanking: when BLANK_LZ = 1, i != 0 and snapshot[31:4i] == 0, then An = 8'hFF, Seg = 7'h7F and Dp = 1. Digit 0 is never blanked.
- Hex table, Seg values:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset asserted mid-frame returns immediately to the reset values; scanning restarts from digit 0 with a full REFRESH_DIV count.
- Until the first frame boundary the display shows snapshot 0: digit 0 reads "0" and the other digits are blank when BLANK_LZ = 1.

Test Plan:
1. Reset: hold Reset = 0 for 3 cycles, then release; REFRESH_DIV = 4, BLANK_LZ = 1.
   -> During reset An = FF, Seg = 7F, Dp = 1, Changed = 0.
   -> From cycle 1 after release: An = FE, Seg = 40, Dp = 1.
2. Scan: v0_In = 32'h89ABCDEF, Sel = 0, BLANK_LZ = 0, run 2 frames.
   -> Second frame, digits 0..7 in order: An = FE,FD,FB,F7,EF,DF,BF,7F with Seg = 0E,06,21,46,03,08,10,00.
   -> Each digit is held exactly 4 cycles.
3. Blanking: v1_In = 32'h0000_0A05, Sel = 1, BLANK_LZ = 1.
   -> Digits 0..2 show 12, 40, 08; digits 3..7 blanked (An = FF).
   -> Dp = 0 only during the digit-0 slot.
4. No tearing: change v0_In from 32'h11111111 to 32'h22222222 while digit index is 3.
   -> Remaining digits 4..7 of that frame still show 79.
   -> The next frame shows 24 on all digits.
   -> Changed rises 1 cycle after that boundary.
5. Change flag:
   - Stable v0_In over 3 frames -> Changed stays 0.
   - Switch Sel 0 -> 1 with v1_In != v0_In -> Changed stays 0.
   - Change v1_In -> Changed = 1 at the next boundary.
   - Assert Ack in the same cycle as a boundary that sets the flag -> Changed stays 1.
   - Assert Ack later -> Changed = 0.
6. Reset mid-frame: assert Reset while index = 5 and snapshot = 32'hFFFFFFFF.
   -> Outputs go to reset values immediately.
   -> After release, digit 0 shows Seg = 40 until the first frame boundary.

Source files
------------

// File: rtl/reg_hex_scan_display.sv
// reg_hex_scan_display: frame-snapshotted 8-digit hex scanner for an active-low
// multiplexed seven-segment display, with leading-zero blanking and a sticky change flag.
`default_nettype none

module reg_hex_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] v0_In,
  input  logic [31:0] v1_In,
  input  logic        Sel,
  input  logic        Ack,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Changed
);

  localparam int unsigned    CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          src_q, src_d;
  logic          changed_q, changed_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          boundary;
  logic [31:0]   sample;
  logic          set_changed;
  logic [31:0]   shifted;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan timing and frame-boundary snapshot / change detection
  always_comb begin
    tick        = (cnt_q == CNT_MAX);
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    boundary    = tick && (idx_q == 3'd7);
    sample      = Sel ? v1_In : v0_In;
    snap_d      = boundary ? sample : snap_q;
    src_d       = boundary ? Sel : src_q;
    set_changed = boundary && (sample != snap_q) && (Sel == src_q);
    changed_d   = set_changed | (changed_q & ~Ack);
  end

  // Display drive is derived from the pre-edge index/snapshot, hence a 1-cycle lag
  always_comb begin
    shifted = snap_q >> {idx_q, 2'b00};
    blank   = BLANK_LZ && (idx_q != 3'd0) && (shifted == 32'd0);
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!blank) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = hex7(shifted[3:0]);
      dp_d  = ~((idx_q == 3'd0) && src_q);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      snap_q    <= 32'd0;
      src_q     <= 1'b0;
      changed_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      src_q     <= src_d;
      changed_q <= changed_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign An      = an_q;
  assign Seg     = seg_q;
  assign Dp      = dp_q;
  assign Changed = changed_q;

endmodule

`default_nettype wire
